dcm_lock_supervisor: RTL and testbench



---
 rtl/dcm_lock_supervisor.sv | 212 +++++++++++++++++++++
 tb/tb_dcm_lock_supervisor.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcm_lock_supervisor.sv
// dcm_lock_supervisor
//   Brings up the DCM that derives the 100 MHz core clock from the 32 MHz
//   reference. It pulses DCM reset, waits for LOCKED, and then requires lock
//   to hold for a settle window. It retries on lost lock or stopped clocks,
//   up to a bounded number of times. While locked it serves single-step
//   phase-shift requests over the PSEN/PSINCDEC/PSDONE handshake. PSCLK is
//   this block's clock.
//
// Ports
//   clock        in   system clock (also DCM PSCLK)
//   reset        in   synchronous, active-high
//   dcm_rst      out  DCM RST
//   dcm_locked   in   DCM LOCKED (asynchronous, synchronized here)
//   dcm_status   in   DCM STATUS (asynchronous); [1] CLKIN stopped, [2] CLKFX stopped
//   ps_req       in   request one phase step (level-sampled while ps_busy=0)
//   ps_dir       in   1 = increment, 0 = decrement
//   ps_busy      out  a request would not be accepted this cycle
//   ps_en        out  DCM PSEN (one-cycle pulse)
//   ps_incdec    out  DCM PSINCDEC (holds its last value between steps)
//   ps_done      in   DCM PSDONE (synchronous to clock)
//   clk_ok       out  DCM locked and qualified
//   retry_count  out  retries since reset, saturating at 255
//   fail         out  retry budget exhausted; cleared only by reset
module dcm_lock_supervisor #(
    parameter int unsigned RST_CYCLES    = 8,
    parameter int unsigned LOCK_TIMEOUT  = 65535,
    parameter int unsigned SETTLE_CYCLES = 256,
    parameter int unsigned PS_TIMEOUT    = 1023,
    parameter int unsigned MAX_RETRIES   = 15
) (
    input  logic       clock,
    input  logic       reset,
    output logic       dcm_rst,
    input  logic       dcm_locked,
    input  logic [7:0] dcm_status,
    input  logic       ps_req,
    input  logic       ps_dir,
    output logic       ps_busy,
    output logic       ps_en,
    output logic       ps_incdec,
    input  logic       ps_done,
    output logic       clk_ok,
    output logic [7:0] retry_count,
    output logic       fail
);

    localparam int unsigned MAX_A   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned MAX_B   = (SETTLE_CYCLES > PS_TIMEOUT) ? SETTLE_CYCLES : PS_TIMEOUT;
    localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] PS_LAST     = CW'(PS_TIMEOUT - 1);
    localparam logic [7:0]    RETRY_LIMIT = (MAX_RETRIES > 255) ? 8'd255 : 8'(MAX_RETRIES);

    typedef enum logic [2:0] {
        RESET_HOLD,
        WAIT_LOCK,
        SETTLE,
        RUN,
        PS_WAIT,
        RETRY,
        FAIL
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          lock_meta_q, lock_q;
    logic [1:0]    stat_meta_q, stat_q;
    logic          dcm_rst_q, clk_ok_q, ps_en_q, ps_incdec_q, ps_busy_q, fail_q;
    logic [7:0]    retry_q;

    logic fault;
    logic ps_done_ok;
    logic to_retry;

    // Only STATUS[2:1] are monitored.
    logic unused_status;
    assign unused_status = ^{dcm_status[7:3], dcm_status[0]};

    assign fault = !lock_q || (stat_q != 2'b00);

    // PSDONE is ignored in the cycle PSEN is still high. The DCM cannot
    // answer the request it is seeing in that cycle, and ignoring it keeps
    // back-to-back steps at least three cycles apart.
    always_comb begin
        ps_done_ok = ps_done && !ps_en_q;
        to_retry   = 1'b0;
        case (state_q)
            WAIT_LOCK:   to_retry = !lock_q && (cnt_q == LOCK_LAST);
            SETTLE, RUN: to_retry = fault;
            PS_WAIT:     to_retry = fault || (!ps_done_ok && (cnt_q == PS_LAST));
            default:     to_retry = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lock_meta_q <= 1'b0;
            lock_q      <= 1'b0;
            stat_meta_q <= '0;
            stat_q      <= '0;
            state_q     <= RESET_HOLD;
            cnt_q       <= '0;
            dcm_rst_q   <= 1'b1;
            clk_ok_q    <= 1'b0;
            ps_en_q     <= 1'b0;
            ps_incdec_q <= 1'b0;
            ps_busy_q   <= 1'b1;
            retry_q     <= '0;
            fail_q      <= 1'b0;
        end else begin
            lock_meta_q <= dcm_locked;
            lock_q      <= lock_meta_q;
            stat_meta_q <= dcm_status[2:1];
            stat_q      <= stat_meta_q;
            ps_en_q     <= 1'b0;

            // All retry causes share one entry path. Its checks have priority
            // over the normal transitions of the same state.
            if (to_retry) begin
                state_q   <= RETRY;
                cnt_q     <= '0;
                dcm_rst_q <= 1'b1;
                clk_ok_q  <= 1'b0;
                ps_busy_q <= 1'b1;
            end else begin
                case (state_q)
                    RESET_HOLD: begin
                        if (cnt_q == RST_LAST) begin
                            state_q   <= WAIT_LOCK;
                            cnt_q     <= '0;
                            dcm_rst_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    WAIT_LOCK: begin
                        if (lock_q) begin
                            state_q <= SETTLE;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    SETTLE: begin
                        if (cnt_q == SETTLE_LAST) begin
                            state_q   <= RUN;
                            cnt_q     <= '0;
                            clk_ok_q  <= 1'b1;
                            ps_busy_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    RUN: begin
                        if (ps_req) begin
                            state_q     <= PS_WAIT;
                            cnt_q       <= '0;
                            ps_en_q     <= 1'b1;
                            ps_incdec_q <= ps_dir;
                            ps_busy_q   <= 1'b1;
                        end
                    end
                    PS_WAIT: begin
                        if (ps_done_ok) begin
                            state_q   <= RUN;
                            cnt_q     <= '0;
                            ps_busy_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    RETRY: begin
                        cnt_q <= '0;
                        if (retry_q >= RETRY_LIMIT) begin
                            state_q <= FAIL;
                            fail_q  <= 1'b1;
                        end else begin
                            state_q <= RESET_HOLD;
                            if (retry_q != 8'hFF) begin
                                retry_q <= retry_q + 8'd1;
                            end
                        end
                    end
                    FAIL: begin
                        cnt_q <= '0;
                    end
                    default: begin
                        state_q   <= FAIL;
                        cnt_q     <= '0;
                        fail_q    <= 1'b1;
                        dcm_rst_q <= 1'b1;
                        clk_ok_q  <= 1'b0;
                        ps_busy_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign dcm_rst     = dcm_rst_q;
    assign clk_ok      = clk_ok_q;
    assign ps_en       = ps_en_q;
    assign ps_incdec   = ps_incdec_q;
    assign ps_busy     = ps_busy_q;
    assign retry_count = retry_q;
    assign fail        = fail_q;

endmodule

// File: tb/tb_dcm_lock_supervisor.sv
// Scoreboard bench for dcm_lock_supervisor. Stimulus pushes expected
// (cycle, output, value) entries. The negedge monitor pops and compares each
// entry when its cycle comes up.
module tb_dcm_lock_supervisor;

    logic       clock = 1'b0;
    logic       reset;
    logic       dcm_rst;
    logic       dcm_locked;
    logic [7:0] dcm_status;
    logic       ps_req;
    logic       ps_dir;
    logic       ps_busy;
    logic       ps_en;
    logic       ps_incdec;
    logic       ps_done;
    logic       clk_ok;
    logic [7:0] retry_count;
    logic       fail;

    dcm_lock_supervisor #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (50),
        .SETTLE_CYCLES(16),
        .PS_TIMEOUT   (20),
        .MAX_RETRIES  (3)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .dcm_rst    (dcm_rst),
        .dcm_locked (dcm_locked),
        .dcm_status (dcm_status),
        .ps_req     (ps_req),
        .ps_dir     (ps_dir),
        .ps_busy    (ps_busy),
        .ps_en      (ps_en),
        .ps_incdec  (ps_incdec),
        .ps_done    (ps_done),
        .clk_ok     (clk_ok),
        .retry_count(retry_count),
        .fail       (fail)
    );

    always #5 clock = ~clock;

    // Number of rising edges seen so far. At a negedge the outputs reflect
    // the state after edge number cyc.
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef enum int {S_RST, S_OK, S_FAIL, S_BUSY, S_EN, S_INCDEC, S_RETRY} sig_e;

    typedef struct {
        int         cyc;
        sig_e       sel;
        logic [7:0] val;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %0d, expected %0d", tag, cyc, obs, exp);
    endtask

    function automatic logic [7:0] observe(input sig_e s);
        case (s)
            S_RST:    return {7'd0, dcm_rst};
            S_OK:     return {7'd0, clk_ok};
            S_FAIL:   return {7'd0, fail};
            S_BUSY:   return {7'd0, ps_busy};
            S_EN:     return {7'd0, ps_en};
            S_INCDEC: return {7'd0, ps_incdec};
            default:  return retry_count;
        endcase
    endfunction

    task automatic sb_push(input int c, input sig_e s, input logic [7:0] v, input string tag);
        exp_t e;
        e.cyc = c;
        e.sel = s;
        e.val = v;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic sb_push_reset(input int c, input string tag);
        sb_push(c, S_RST,    8'd1, {tag, ".dcm_rst"});
        sb_push(c, S_OK,     8'd0, {tag, ".clk_ok"});
        sb_push(c, S_FAIL,   8'd0, {tag, ".fail"});
        sb_push(c, S_BUSY,   8'd1, {tag, ".ps_busy"});
        sb_push(c, S_EN,     8'd0, {tag, ".ps_en"});
        sb_push(c, S_INCDEC, 8'd0, {tag, ".ps_incdec"});
        sb_push(c, S_RETRY,  8'd0, {tag, ".retry"});
    endtask

    // Moves to the negedge that follows rising edge number n.
    task automatic goto(input int n);
        while (cyc < n) @(negedge clock);
    endtask

    always @(negedge clock) begin : monitor
        int i;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].cyc <= cyc) begin
                check(sb[i].tag, observe(sb[i].sel), sb[i].val);
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        int b;
        reset      = 1'b1;
        dcm_locked = 1'b0;
        dcm_status = '0;
        ps_req     = 1'b0;
        ps_dir     = 1'b0;
        ps_done    = 1'b0;

        // A: reset values, bring-up, lock 10 cycles after release.
        goto(1);
        sb_push_reset(2, "A.reset");
        goto(3);
        reset = 1'b0;
        b = 3;
        sb_push(b + 3,  S_RST,   8'd1, "A.rst_4th_cycle");
        sb_push(b + 4,  S_RST,   8'd0, "A.rst_released");
        sb_push(b + 28, S_OK,    8'd0, "A.ok_before_settle");
        sb_push(b + 28, S_BUSY,  8'd1, "A.busy_before_run");
        sb_push(b + 29, S_OK,    8'd1, "A.ok_after_settle");
        sb_push(b + 29, S_BUSY,  8'd0, "A.busy_in_run");
        sb_push(b + 29, S_RETRY, 8'd0, "A.retry");
        goto(b + 10);
        dcm_locked = 1'b1;

        // B: increment step, ignored request while busy, then decrement step.
        goto(40);
        b = 40;
        ps_req = 1'b1;
        ps_dir = 1'b1;
        sb_push(b + 1,  S_EN,     8'd1, "B.psen_pulse");
        sb_push(b + 1,  S_INCDEC, 8'd1, "B.incdec_up");
        sb_push(b + 1,  S_BUSY,   8'd1, "B.busy_set");
        sb_push(b + 2,  S_EN,     8'd0, "B.psen_one_cycle");
        sb_push(b + 5,  S_EN,     8'd0, "B.busy_req_ignored");
        sb_push(b + 6,  S_EN,     8'd0, "B.busy_req_ignored2");
        sb_push(b + 6,  S_INCDEC, 8'd1, "B.incdec_holds");
        sb_push(b + 10, S_OK,     8'd1, "B.ok_in_ps_wait");
        sb_push(b + 12, S_BUSY,   8'd1, "B.busy_until_done");
        sb_push(b + 13, S_BUSY,   8'd0, "B.busy_cleared");
        sb_push(b + 14, S_EN,     8'd0, "B.no_queued_req");
        goto(b + 1);
        ps_req = 1'b0;
        goto(b + 4);
        ps_req = 1'b1;
        ps_dir = 1'b0;
        goto(b + 5);
        ps_req = 1'b0;
        goto(b + 12);
        ps_done = 1'b1;
        goto(b + 13);
        ps_done = 1'b0;

        goto(60);
        b = 60;
        ps_req = 1'b1;
        ps_dir = 1'b0;
        sb_push(b + 1, S_EN,     8'd1, "B.dec_psen");
        sb_push(b + 1, S_INCDEC, 8'd0, "B.dec_incdec");
        sb_push(b + 2, S_EN,     8'd0, "B.dec_psen_off");
        sb_push(b + 3, S_BUSY,   8'd1, "B.dec_busy");
        sb_push(b + 4, S_BUSY,   8'd0, "B.dec_done");
        sb_push(b + 5, S_INCDEC, 8'd0, "B.dec_incdec_holds");
        goto(b + 1);
        ps_req = 1'b0;
        goto(b + 3);
        ps_done = 1'b1;
        goto(b + 4);
        ps_done = 1'b0;

        // C: one-cycle lock glitch in RUN, full re-sequence.
        goto(70);
        b = 70;
        dcm_locked = 1'b0;
        sb_push(b + 2,  S_OK,    8'd1, "C.ok_before_fault");
        sb_push(b + 3,  S_OK,    8'd0, "C.ok_dropped");
        sb_push(b + 3,  S_RST,   8'd1, "C.rst_retry");
        sb_push(b + 3,  S_RETRY, 8'd0, "C.retry_before");
        sb_push(b + 4,  S_RETRY, 8'd1, "C.retry_after");
        sb_push(b + 7,  S_RST,   8'd1, "C.rst_hold_end");
        sb_push(b + 8,  S_RST,   8'd0, "C.rst_released");
        sb_push(b + 24, S_OK,    8'd0, "C.ok_settling");
        sb_push(b + 25, S_OK,    8'd1, "C.ok_back");
        goto(b + 1);
        dcm_locked = 1'b1;

        // D: phase step whose PSDONE never arrives.
        goto(100);
        b = 100;
        ps_req = 1'b1;
        ps_dir = 1'b1;
        sb_push(b + 20, S_OK,    8'd1, "D.ok_before_timeout");
        sb_push(b + 20, S_RST,   8'd0, "D.rst_before_timeout");
        sb_push(b + 20, S_BUSY,  8'd1, "D.busy_waiting");
        sb_push(b + 21, S_OK,    8'd0, "D.ok_timeout");
        sb_push(b + 21, S_RST,   8'd1, "D.rst_timeout");
        sb_push(b + 21, S_EN,    8'd0, "D.psen_low");
        sb_push(b + 22, S_RETRY, 8'd2, "D.retry");
        sb_push(b + 42, S_OK,    8'd0, "D.ok_settling");
        sb_push(b + 43, S_OK,    8'd1, "D.ok_back");
        goto(b + 1);
        ps_req = 1'b0;

        // F: reset in PS_WAIT with ps_req held, then a STATUS[1] pulse in SETTLE.
        goto(150);
        b = 150;
        ps_req = 1'b1;
        ps_dir = 1'b1;
        sb_push(b + 1, S_EN,     8'd1, "F.psen");
        sb_push(b + 1, S_INCDEC, 8'd1, "F.incdec");
        for (int k = 4; k <= 6; k++) sb_push_reset(b + k, "F.reset");
        goto(b + 1);
        ps_req = 1'b0;
        goto(b + 3);
        reset  = 1'b1;
        ps_req = 1'b1;
        goto(b + 6);
        reset  = 1'b0;
        ps_req = 1'b0;
        b = 156;
        for (int k = 1; k <= 3; k++) sb_push(b + k, S_EN, 8'd0, "F.no_psen");
        sb_push(b + 10, S_RST,   8'd0, "F.rst_in_settle");
        sb_push(b + 11, S_RST,   8'd1, "F.rst_status_retry");
        sb_push(b + 11, S_OK,    8'd0, "F.ok_status_retry");
        sb_push(b + 12, S_RETRY, 8'd1, "F.retry");
        sb_push(b + 21, S_OK,    8'd0, "F.no_early_run");
        sb_push(b + 32, S_OK,    8'd0, "F.ok_settling");
        sb_push(b + 33, S_OK,    8'd1, "F.ok_back");
        goto(b + 8);
        dcm_status = 8'b0000_0010;
        goto(b + 9);
        dcm_status = '0;

        // E: STATUS[2] pulse in RUN.
        goto(196);
        b = 196;
        dcm_status = 8'b0000_0100;
        sb_push(b + 2,  S_OK,    8'd1, "E.ok_before");
        sb_push(b + 3,  S_OK,    8'd0, "E.ok_dropped");
        sb_push(b + 3,  S_RST,   8'd1, "E.rst_retry");
        sb_push(b + 4,  S_RETRY, 8'd2, "E.retry");
        sb_push(b + 25, S_OK,    8'd1, "E.ok_back");
        goto(b + 1);
        dcm_status = '0;

        // G: no lock at all, retry budget runs out.
        goto(226);
        reset      = 1'b1;
        dcm_locked = 1'b0;
        sb_push_reset(228, "G.reset");
        goto(229);
        reset = 1'b0;
        b = 229;
        sb_push(b + 1,   S_RETRY, 8'd0, "G.retry_cleared");
        sb_push(b + 53,  S_RST,   8'd0, "G.rst_wait1");
        sb_push(b + 54,  S_RST,   8'd1, "G.rst_retry1");
        sb_push(b + 55,  S_RETRY, 8'd1, "G.retry1");
        sb_push(b + 108, S_RST,   8'd0, "G.rst_wait2");
        sb_push(b + 109, S_RST,   8'd1, "G.rst_retry2");
        sb_push(b + 110, S_RETRY, 8'd2, "G.retry2");
        sb_push(b + 165, S_RETRY, 8'd3, "G.retry3");
        sb_push(b + 219, S_FAIL,  8'd0, "G.fail_not_yet");
        sb_push(b + 220, S_FAIL,  8'd1, "G.fail_set");
        sb_push(b + 220, S_RETRY, 8'd3, "G.retry_final");
        sb_push(b + 220, S_RST,   8'd1, "G.rst_in_fail");
        sb_push(b + 220, S_BUSY,  8'd1, "G.busy_in_fail");
        sb_push(b + 260, S_FAIL,  8'd1, "G.fail_sticky");
        sb_push(b + 260, S_OK,    8'd0, "G.ok_in_fail");
        sb_push(b + 260, S_RST,   8'd1, "G.rst_sticky");
        goto(b + 225);
        dcm_locked = 1'b1;
        goto(b + 262);

        check("sb_drain", 8'(sb.size()), 8'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
